// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: sync-stage state encoding and default frame geometry.
// No logic; latency and backpressure are properties of the stages that import it.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vtState;

  localparam int defBusWidth    = 11;
  localparam int defResVertical = 1080;
  localparam int defFrontPorch  = 4;
  localparam int defSyncWidth   = 5;
  localparam int defBackPorch   = 36;

endpackage

// File: rtl/pulse_rise_detect.sv
// Rising-edge detector: one registered cycle of 'out' per low-to-high transition of 'in'.
// Latency 1 cycle; no backpressure, a held-high input yields a single pulse.
module pulse_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic inDly;

  always_ff @(posedge clock) begin
    if (reset) begin
      inDly <= 1'b0;
      out   <= 1'b0;
    end else begin
      inDly <= in;
      out   <= in & ~inDly;
    end
  end

endmodule

// File: rtl/vsync_timing.sv
// Vertical timing: counts line ticks, walks ACTIVE/FRONT/SYNC/BACK, drives vSyncPulse/vActive/frameStart.
// Latency: registered outputs update one cycle after a detected tick; no backpressure, ticks never stall.
module vsync_timing
  import video_timing_pkg::*;
#(
  parameter int busWidth    = defBusWidth,
  parameter int resVertical = defResVertical,
  parameter int vFrontPorch = defFrontPorch,
  parameter int vSyncWidth  = defSyncWidth,
  parameter int vBackPorch  = defBackPorch
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hSyncPulse,
  output logic                vSyncPulse,
  output logic                vActive,
  output logic [busWidth-1:0] lineCount,
  output logic                frameStart
);

  localparam int total = resVertical + vFrontPorch + vSyncWidth + vBackPorch;

  // Shift is only meaningful below 31 bits; wider counters always hold any int-sized total.
  if ((vFrontPorch < 1) || (vSyncWidth < 1) || (vBackPorch < 1) ||
      ((busWidth < 31) && (total > (1 << busWidth)))) begin : gBadGeometry
    $fatal(1, "vsync_timing: illegal frame geometry for the configured busWidth");
  end

  localparam logic [busWidth-1:0] lastLine   = busWidth'(total - 1);
  localparam logic [busWidth-1:0] frontStart = busWidth'(resVertical);
  localparam logic [busWidth-1:0] syncStart  = busWidth'(resVertical + vFrontPorch);
  localparam logic [busWidth-1:0] backStart  = busWidth'(resVertical + vFrontPorch + vSyncWidth);

  logic                lineTick;
  vtState              state;
  vtState              nextState;
  logic [busWidth-1:0] nextLine;
  logic                nextFrameStart;

  pulse_rise_detect uTickDetect (
    .clock (clock),
    .reset (reset),
    .in    (hSyncPulse),
    .out   (lineTick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ACTIVE;
      lineCount  <= '0;
      vActive    <= 1'b1;
      vSyncPulse <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      state      <= nextState;
      lineCount  <= nextLine;
      vActive    <= (nextState == ACTIVE);
      vSyncPulse <= (nextState == SYNC);
      frameStart <= nextFrameStart;
    end
  end

  // State follows the updated line index, so region boundaries are pure comparisons.
  always_comb begin
    nextLine       = lineCount;
    nextState      = state;
    nextFrameStart = 1'b0;
    if (lineTick) begin
      if (lineCount == lastLine) begin
        nextLine       = '0;
        nextFrameStart = 1'b1;
      end else begin
        nextLine = lineCount + busWidth'(1);
      end
      if (nextLine < frontStart) begin
        nextState = ACTIVE;
      end else if (nextLine < syncStart) begin
        nextState = FRONT;
      end else if (nextLine < backStart) begin
        nextState = SYNC;
      end else begin
        nextState = BACK;
      end
    end
  end

endmodule

// File: doc/vsync_timing.md
VSYNC_TIMING -- requirements
Module: vsync_timing

Interface
REQ-001 Parameter busWidth, default 11, SHALL set the width of all line counters; its maximum value is 2047.
REQ-002 Parameter resVertical, default 1080, SHALL be the number of active lines per frame.
REQ-003 Parameter vFrontPorch, default 4, SHALL be the number of front-porch lines; legal range 1 or more.
REQ-004 Parameter vSyncWidth, default 5, SHALL be the number of sync lines; legal range 1 or more.
REQ-005 Parameter vBackPorch, default 36, SHALL be the number of back-porch lines; legal range 1 or more.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 Port clock, input, 1 bit: pixel clock; all logic SHALL be on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous reset, active high.
REQ-009 Port hSyncPulse, input, 1 bit: end-of-line pulse from the horizontal sync stage, in the clock domain.
REQ-010 Port vSyncPulse, output, 1 bit: high for every line in the SYNC state.
REQ-011 Port vActive, output, 1 bit: high for every line in the ACTIVE state.
REQ-012 Port lineCount, output, busWidth bits: frame line index, range 0 to total-1.
REQ-013 Port frameStart, output, 1 bit: one-cycle pulse when a new frame begins.

Function
REQ-014 total SHALL be resVertical + vFrontPorch + vSyncWidth + vBackPorch, and SHALL be at most 2^busWidth; elaboration SHALL fail if it is larger.
REQ-015 A line tick SHALL be a rising edge of hSyncPulse (high this cycle, registered copy low); a pulse held high for N cycles SHALL count as one tick.
REQ-016 The state machine SHALL have states ACTIVE, FRONT, SYNC and BACK, visited in that order and wrapping from BACK to ACTIVE.
REQ-017 On each tick, lineCount SHALL increment; at total-1 it SHALL wrap to 0.
REQ-018 State transitions SHALL follow the new lineCount: ACTIVE for 0 to resVertical-1, FRONT for the next vFrontPorch lines, SYNC for the next vSyncWidth lines, BACK for the rest.
REQ-019 All outputs SHALL be registered; a tick sampled at edge k SHALL update outputs after edge k+1 (latency 1 cycle after the tick is detected).
REQ-020 vSyncPulse SHALL equal (state == SYNC), and vActive SHALL equal (state == ACTIVE).
REQ-021 frameStart SHALL be high for exactly one cycle, coinciding with the lineCount update to 0 on wrap.
REQ-022 With no ticks, all outputs SHALL hold indefinitely.
REQ-023 When a tick and reset occur in the same cycle, reset SHALL win and the tick SHALL be discarded.
REQ-024 Counter arithmetic SHALL be unsigned, busWidth wide, with no overflow beyond total-1.

Reset
REQ-025 On reset, state SHALL be ACTIVE, lineCount 0, vActive 1, vSyncPulse 0, frameStart 0, and the edge-detect register 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; the first tick after release SHALL give lineCount 1 with no frameStart.
REQ-027 After reset the first frameStart SHALL occur only on the first wrap.

Structure
REQ-028 The state encoding (2 bits: ACTIVE=0, FRONT=1, SYNC=2, BACK=3) and the default timing constants SHALL live in a shared video timing package used by the sync stages.
REQ-029 The edge detector SHALL be a sub-module named pulse_rise_detect (clock, reset, in, out), reusable by other stages.
REQ-030 All other logic SHALL be flat within vsync_timing.

Verification
REQ-031 With resVertical=4, vFrontPorch=1, vSyncWidth=2, vBackPorch=1 (total 8), feeding 8 single-cycle ticks -> lineCount 1..7 then 0; vActive high for lines 0-3; vSyncPulse high for lines 5-6; frameStart exactly once, with lineCount 0.
REQ-032 A 3-cycle-wide hSyncPulse -> lineCount advances by exactly 1.
REQ-033 Reset asserted at lineCount 5 (SYNC) -> next cycle lineCount 0, vSyncPulse 0, vActive 1; the next tick gives lineCount 1 with frameStart 0.
REQ-034 A tick in the same cycle as reset -> lineCount 0 after the edge.
REQ-035 Default parameters, 1125 ticks -> vSyncPulse high for 5 lines at lineCount 1084-1088; frameStart once; lineCount back at 0.
REQ-036 No ticks for 10000 cycles after reset -> outputs constant at their reset values.
